// File: rtl/router_dest_reader_if.sv
// Port bundle for the destination-side drain of one router output port.
// master = the reader block, slave = the FIFO/consumer side that drives it.
interface router_dest_reader_if #(
    parameter int LEN_W   = 6,
    parameter int ADDR_W  = 2,
    parameter int DELAY_W = 5
);
    localparam int DW = LEN_W + ADDR_W;

    // Read handshake: a byte is popped when read_enb & vld_out are both high at a
    // rising edge; that byte is presented on data_out during the following cycle.
    logic               vld_out;
    logic [DW-1:0]      data_out;
    logic               soft_reset;
    logic [DELAY_W-1:0] delay_cfg;
    logic               hold;

    logic               read_enb;
    logic [DW-1:0]      byte_out;
    logic               byte_valid;
    logic [LEN_W-1:0]   pkt_len;
    logic [ADDR_W-1:0]  pkt_addr;
    logic               pkt_done;
    logic               parity_err;
    logic               pkt_abort;
    logic               busy;
    logic [1:0]         state_dbg;

    modport master (
        input  vld_out, data_out, soft_reset, delay_cfg, hold,
        output read_enb, byte_out, byte_valid, pkt_len, pkt_addr,
               pkt_done, parity_err, pkt_abort, busy, state_dbg
    );

    modport slave (
        output vld_out, data_out, soft_reset, delay_cfg, hold,
        input  read_enb, byte_out, byte_valid, pkt_len, pkt_addr,
               pkt_done, parity_err, pkt_abort, busy, state_dbg
    );
endinterface

// File: rtl/router_dest_reader.sv
// Drains one packet (header, payload, parity) from a router output FIFO after a
// programmable delay, streams the payload and reports parity errors or aborts.
module router_dest_reader #(
    parameter int LEN_W   = 6,
    parameter int ADDR_W  = 2,
    parameter int DELAY_W = 5
) (
    input  logic                  clk,
    input  logic                  resetn,
    router_dest_reader_if.master  bus
);
    localparam int DW = LEN_W + ADDR_W;
    localparam logic [LEN_W:0]   CNT_ONE = 1;
    localparam logic [LEN_W:0]   CNT_TWO = 2;
    localparam logic [DELAY_W-1:0] DLY_ONE = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        READ  = 2'd2,
        CHECK = 2'd3
    } state_t;

    state_t             state, state_nx;
    logic [DELAY_W-1:0] dly_cnt;
    logic [LEN_W:0]     issued;
    logic [LEN_W:0]     captured;
    logic               hdr_seen;
    logic               rd_pending;
    logic [DW-1:0]      acc;
    logic [DW-1:0]      parity_q;
    logic [DW-1:0]      byte_out_q;
    logic               byte_valid_q;
    logic [LEN_W-1:0]   pkt_len_q;
    logic [ADDR_W-1:0]  pkt_addr_q;
    logic               pkt_abort_q;

    logic               active;
    logic               abort;
    logic [LEN_W:0]     len_ext;
    logic [LEN_W:0]     target;
    logic               read_enb;
    logic               is_parity;

    // Counters are one bit wider than the length field so len+2 never wraps.
    always_comb begin
        active    = (state == DELAY) || (state == READ);
        abort     = bus.soft_reset && active;
        len_ext   = {1'b0, pkt_len_q};
        target    = hdr_seen ? (len_ext + CNT_TWO) : CNT_TWO;
        read_enb  = (state == READ) && !bus.soft_reset && !bus.hold &&
                    bus.vld_out && (issued < target);
        is_parity = rd_pending && hdr_seen && (captured == (len_ext + CNT_ONE));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.vld_out) begin
                    state_nx = (bus.delay_cfg == '0) ? READ : DELAY;
                end
            end
            DELAY: begin
                if (bus.soft_reset) begin
                    state_nx = IDLE;
                end else if (dly_cnt <= DLY_ONE) begin
                    state_nx = READ;
                end
            end
            READ: begin
                // An abort beats a parity capture landing in the same cycle.
                if (bus.soft_reset) begin
                    state_nx = IDLE;
                end else if (is_parity) begin
                    state_nx = CHECK;
                end
            end
            CHECK: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dly_cnt      <= '0;
            issued       <= '0;
            captured     <= '0;
            hdr_seen     <= 1'b0;
            rd_pending   <= 1'b0;
            acc          <= '0;
            parity_q     <= '0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            pkt_len_q    <= '0;
            pkt_addr_q   <= '0;
            pkt_abort_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            pkt_abort_q  <= abort;
            if (abort || (state == IDLE)) begin
                // Per-packet bookkeeping restarts; an in-flight byte is dropped.
                issued     <= '0;
                captured   <= '0;
                hdr_seen   <= 1'b0;
                rd_pending <= 1'b0;
                acc        <= '0;
                if ((state == IDLE) && bus.vld_out) begin
                    dly_cnt <= bus.delay_cfg;
                end else begin
                    dly_cnt <= '0;
                end
            end else if (state == DELAY) begin
                dly_cnt <= (dly_cnt == '0) ? '0 : (dly_cnt - DLY_ONE);
            end else if (state == READ) begin
                rd_pending <= read_enb;
                if (read_enb) begin
                    issued <= issued + CNT_ONE;
                end
                if (rd_pending) begin
                    captured <= captured + CNT_ONE;
                    if (!hdr_seen) begin
                        {pkt_len_q, pkt_addr_q} <= bus.data_out;
                        acc      <= bus.data_out;
                        hdr_seen <= 1'b1;
                    end else if (is_parity) begin
                        parity_q <= bus.data_out;
                    end else begin
                        byte_out_q   <= bus.data_out;
                        byte_valid_q <= 1'b1;
                        acc          <= acc ^ bus.data_out;
                    end
                end
            end
        end
    end

    assign bus.read_enb   = read_enb;
    assign bus.byte_out   = byte_out_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.pkt_len    = pkt_len_q;
    assign bus.pkt_addr   = pkt_addr_q;
    assign bus.pkt_done   = (state == CHECK);
    assign bus.parity_err = (state == CHECK) && (acc != parity_q);
    assign bus.pkt_abort  = pkt_abort_q;
    assign bus.busy       = (state != IDLE);
    assign bus.state_dbg  = state;
endmodule
